// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared definitions for the data-memory port arbiter.
//   own_e       - owner state encoding (IDLE / OWN0 / OWN1)
//   mem_req_t   - one memory-port request (addr, byte enables, write data)
//   *_DEF       - default starvation / burst limits
//   sat_inc     - 4-bit saturating increment used by the arbiter counters
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } mem_req_t;

  localparam int MAX_WAIT_DEF  = 4;
  localparam int MAX_BURST_DEF = 8;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/dm_arbiter_port_mux.sv
// arb_port_mux: combinational owner-select for the shared memory port.
//   own        - current owner from the arbiter FSM
//   m0_*/m1_*  - requester valid + request payload
//   mem_rdata  - asynchronous read data from memory
//   mx_gnt     - beat accepted this cycle (owner with req high)
//   mx_rdata   - mem_rdata routed to the granted master, 0 otherwise
//   mem_rq     - payload presented to memory; all-zero when nobody is granted,
//                so a non-owner can never write
module arb_port_mux
  import dm_arbiter_pkg::*;
(
  input  own_e        own,
  input  logic        m0_req,
  input  mem_req_t    m0_rq,
  input  logic        m1_req,
  input  mem_req_t    m1_rq,
  input  logic [31:0] mem_rdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output mem_req_t    mem_rq
);

  assign m0_gnt   = (own == OWN0) & m0_req;
  assign m1_gnt   = (own == OWN1) & m1_req;
  assign m0_rdata = m0_gnt ? mem_rdata : 32'h0;
  assign m1_rdata = m1_gnt ? mem_rdata : 32'h0;

  always_comb begin
    mem_rq = '0;
    if (m0_gnt)      mem_rq = m0_rq;
    else if (m1_gnt) mem_rq = m1_rq;
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU M stage
// (master 0) and a DMA/peripheral engine (master 1).
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   m0_*              - CPU request/grant/read data; cpu_stall = m0_req & ~m0_gnt
//   m1_*              - master 1 request/grant/read data; m1_lock keeps the
//                       port for up to MAX_BURST consecutive beats
//   mem_*             - memory port (combinational read data)
// Build option: DM_ARB_RR_EN selects round-robin priority instead of fixed
// CPU priority with the MAX_WAIT starvation escape.
// Ownership takes effect the cycle after the request is seen; an owner with
// its request held gets a beat every cycle.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_byteen,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        cpu_stall,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_byteen,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] WAIT_LIM  = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

  own_e       own, own_nxt;
  logic [3:0] wait_cnt, burst_cnt;
  logic       burst_hold, pick1;
  mem_req_t   m0_rq, m1_rq, mem_rq;

  assign m0_rq = '{addr: m0_addr, byteen: m0_byteen, wdata: m0_wdata};
  assign m1_rq = '{addr: m1_addr, byteen: m1_byteen, wdata: m1_wdata};

  arb_port_mux u_mux (
    .own      (own),
    .m0_req   (m0_req),
    .m0_rq    (m0_rq),
    .m1_req   (m1_req),
    .m1_rq    (m1_rq),
    .mem_rdata(mem_rdata),
    .m0_gnt   (m0_gnt),
    .m1_gnt   (m1_gnt),
    .m0_rdata (m0_rdata),
    .m1_rdata (m1_rdata),
    .mem_rq   (mem_rq)
  );

  assign mem_addr   = mem_rq.addr;
  assign mem_byteen = mem_rq.byteen;
  assign mem_wdata  = mem_rq.wdata;
  assign cpu_stall  = m0_req & ~m0_gnt;

`ifdef DM_ARB_RR_EN
  // last_m1: master 1 took the most recent beat. Resets to 1 so the CPU
  // wins the very first contention.
  logic last_m1, last_m1_eff;
  assign last_m1_eff = m0_gnt ? 1'b0 : (m1_gnt ? 1'b1 : last_m1);
  assign pick1       = ~last_m1_eff;
`else
  // A master 1 being granted this cycle is no longer waiting, so its stale
  // count must not keep the port away from the CPU next cycle.
  assign pick1 = (wait_cnt >= WAIT_LIM) & ~m1_gnt;
`endif

  always_comb begin
    own_nxt    = IDLE;
    burst_hold = (own == OWN1) & m1_lock & (burst_cnt < BURST_LIM);
    unique case ({m0_req, m1_req})
      2'b10:   own_nxt = OWN0;
      2'b01:   own_nxt = OWN1;
      2'b11:   own_nxt = (burst_hold | pick1) ? OWN1 : OWN0;
      default: own_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own       <= IDLE;
      wait_cnt  <= 4'd0;
      burst_cnt <= 4'd0;
    end else begin
      own <= own_nxt;
`ifdef DM_ARB_RR_EN
      wait_cnt <= 4'd0;
`else
      wait_cnt <= (m1_req & ~m1_gnt) ? sat_inc(wait_cnt) : 4'd0;
`endif
      if (own_nxt != OWN1) burst_cnt <= 4'd0;
      else if (m1_gnt)     burst_cnt <= sat_inc(burst_cnt);
    end
  end

`ifdef DM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_m1 <= 1'b1;
    else       last_m1 <= last_m1_eff;
  end
`endif

endmodule
